// File: rtl/hydra_arb_pkg.sv
// ============================================================================
// Module      : hydra_arb_pkg
// Description : Shared constants and FSM state encoding for the SRAM read
//               arbiter (port count, field widths, watchdog limit).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hydra_arb_pkg;

    localparam int PORT_NUM   = 16;
    localparam int PORT_W     = 4;
    localparam int LEN_W      = 6;
    localparam int WDOG_LIMIT = 255;
    localparam int WDOG_W     = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

endpackage : hydra_arb_pkg

`default_nettype wire

// File: rtl/sram_rd_arbiter_if.sv
// ============================================================================
// Module      : sram_rd_arbiter_if
// Description : Request/grant/beat signal bundle between the requesting ports
//               and the SRAM read arbiter. The master side drives requests and
//               SRAM readiness; the slave side (the arbiter) drives grants.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sram_rd_arbiter_if #(
    parameter int PORT_NUM = hydra_arb_pkg::PORT_NUM,
    parameter int LEN_W    = hydra_arb_pkg::LEN_W
) ();
    import hydra_arb_pkg::*;

    logic [PORT_NUM-1:0]       rd_req;
    logic [PORT_NUM*LEN_W-1:0] rd_len;
    logic                      sram_ready;
    logic                      grant_valid;
    logic [PORT_W-1:0]         grant_port;
    logic [PORT_NUM-1:0]       grant_onehot;
    logic                      beat_fire;
    logic [LEN_W-1:0]          beat_idx;
    logic                      burst_done;
    logic                      burst_abort;

    modport master (
        output rd_req, rd_len, sram_ready,
        input  grant_valid, grant_port, grant_onehot, beat_fire,
               beat_idx, burst_done, burst_abort
    );

    modport slave (
        input  rd_req, rd_len, sram_ready,
        output grant_valid, grant_port, grant_onehot, beat_fire,
               beat_idx, burst_done, burst_abort
    );

endinterface : sram_rd_arbiter_if

`default_nettype wire

// File: rtl/rr_select_16.sv
// ============================================================================
// Module      : rr_select_16
// Description : Combinational rotating-priority picker. Returns the first set
//               request bit found scanning upward from (rr_ptr+1) with wrap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_select_16 #(
    parameter int PORT_NUM = hydra_arb_pkg::PORT_NUM,
    parameter int PORT_W   = hydra_arb_pkg::PORT_W
) (
    input  logic [PORT_NUM-1:0] req_i,
    input  logic [PORT_W-1:0]   rr_ptr_i,
    output logic                found_o,
    output logic [PORT_W-1:0]   index_o
);
    import hydra_arb_pkg::*;

    // Scan farthest-first so the nearest requester after rr_ptr overwrites last
    always_comb begin
        int                pos;
        logic [PORT_W-1:0] pos_w;
        found_o = 1'b0;
        index_o = '0;
        pos     = 0;
        pos_w   = '0;
        for (int k = PORT_NUM; k >= 1; k--) begin
            pos   = (int'(rr_ptr_i) + k) % PORT_NUM;
            pos_w = PORT_W'(pos);
            if (req_i[pos_w]) begin
                found_o = 1'b1;
                index_o = pos_w;
            end
        end
    end

endmodule : rr_select_16

`default_nettype wire

// File: rtl/sram_rd_arbiter.sv
// ============================================================================
// Module      : sram_rd_arbiter
// Description : Round-robin arbiter granting whole read bursts on a single
//               SRAM read port. A burst is frozen once granted and advances
//               one beat per cycle in which the SRAM is ready.
//               Optional watchdog (macro SRAM_RD_ARB_WDOG_EN) aborts a burst
//               after 255 consecutive stalled cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_rd_arbiter #(
    parameter int PORT_NUM = hydra_arb_pkg::PORT_NUM,
    parameter int LEN_W    = hydra_arb_pkg::LEN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    sram_rd_arbiter_if.slave bus
);
    import hydra_arb_pkg::*;

    // rd_len == 0 encodes the maximum burst of 2^LEN_W beats
    localparam logic [LEN_W:0] REM_FULL = {1'b1, {LEN_W{1'b0}}};
    localparam logic [LEN_W:0] REM_ONE  = {{LEN_W{1'b0}}, 1'b1};

    arb_state_e           state_q;
    logic [PORT_W-1:0]    rr_ptr_q;
    logic [PORT_W-1:0]    grant_port_q;
    logic [PORT_NUM-1:0]  grant_onehot_q;
    logic [LEN_W:0]       remaining_q;
    logic [LEN_W-1:0]     beat_idx_q;

    logic                 w_pick_found;
    logic [PORT_W-1:0]    w_pick_idx;
    logic [LEN_W-1:0]     w_pick_len;
    logic [PORT_NUM-1:0]  w_pick_onehot;
    logic [LEN_W:0]       w_pick_remaining;
    logic                 w_in_burst;
    logic                 w_beat_fire;
    logic                 w_last_beat;
    logic                 w_abort;

    rr_select_16 #(
        .PORT_NUM (PORT_NUM),
        .PORT_W   (PORT_W)
    ) u_rr_select (
        .req_i    (bus.rd_req),
        .rr_ptr_i (rr_ptr_q),
        .found_o  (w_pick_found),
        .index_o  (w_pick_idx)
    );

    // Decode the picked port into its burst length and one-hot grant vector
    always_comb begin
        w_pick_len    = '0;
        w_pick_onehot = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            if (w_pick_idx == PORT_W'(p)) begin
                w_pick_len       = bus.rd_len[p*LEN_W +: LEN_W];
                w_pick_onehot[p] = 1'b1;
            end
        end
        w_pick_remaining = (w_pick_len == '0) ? REM_FULL : {1'b0, w_pick_len};
    end

    assign w_in_burst  = (state_q == BURST);
    assign w_beat_fire = w_in_burst & bus.sram_ready;
    assign w_last_beat = w_beat_fire & (remaining_q == REM_ONE);

`ifdef SRAM_RD_ARB_WDOG_EN
    logic [WDOG_W-1:0] wdog_q;

    // The abort fires on the 255th consecutive stalled cycle of a burst
    assign w_abort = w_in_burst & ~bus.sram_ready
                   & (wdog_q == WDOG_W'(WDOG_LIMIT - 1));

    // Count consecutive stalled burst cycles; any accepted beat restarts it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= '0;
        end else if (!w_in_burst || w_beat_fire || w_abort) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_q + 1'b1;
        end
    end
`else
    assign w_abort = 1'b0;
`endif

    // Arbitration FSM: pick in IDLE, hold the grant frozen through BURST
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            rr_ptr_q       <= PORT_W'(PORT_NUM - 1);
            grant_port_q   <= '0;
            grant_onehot_q <= '0;
            remaining_q    <= '0;
            beat_idx_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_pick_found) begin
                        state_q        <= BURST;
                        grant_port_q   <= w_pick_idx;
                        grant_onehot_q <= w_pick_onehot;
                        remaining_q    <= w_pick_remaining;
                        beat_idx_q     <= '0;
                    end
                end
                BURST: begin
                    if (w_last_beat || w_abort) begin
                        state_q        <= IDLE;
                        rr_ptr_q       <= grant_port_q;
                        grant_onehot_q <= '0;
                        remaining_q    <= '0;
                        beat_idx_q     <= '0;
                    end else if (w_beat_fire) begin
                        remaining_q    <= remaining_q - 1'b1;
                        beat_idx_q     <= beat_idx_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant_valid  = w_in_burst;
    assign bus.grant_port   = grant_port_q;
    assign bus.grant_onehot = grant_onehot_q & {PORT_NUM{w_in_burst}};
    assign bus.beat_fire    = w_beat_fire;
    assign bus.beat_idx     = beat_idx_q;
    assign bus.burst_done   = w_last_beat;
    assign bus.burst_abort  = w_abort;

endmodule : sram_rd_arbiter

`default_nettype wire

// File: tb/tb_sram_rd_arbiter.sv
// ============================================================================
// Module      : tb_sram_rd_arbiter
// Description : Directed self-checking bench for sram_rd_arbiter.
//               Watchdog scenario follows macro SRAM_RD_ARB_WDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_rd_arbiter;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    sram_rd_arbiter_if #(.PORT_NUM(16), .LEN_W(6)) bus ();

    sram_rd_arbiter #(.PORT_NUM(16), .LEN_W(6)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_len(input int port, input logic [5:0] len);
        bus.rd_len[port*6 +: 6] = len;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        bus.rd_req     = '0;
        bus.rd_len     = '0;
        bus.sram_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Bounded wait (at negedges) for grant_valid
    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.grant_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        bus.rd_req     = 16'hFFFF;
        bus.rd_len     = '0;
        bus.sram_ready = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (bus.grant_valid !== 1'b0 || bus.grant_port !== 4'd0 || bus.grant_onehot !== 16'h0 ||
            bus.beat_idx !== 6'd0 || bus.burst_done !== 1'b0 || bus.burst_abort !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: valid=%b port=%0d oh=%h idx=%0d done=%b abort=%b want all zero",
                     bus.grant_valid, bus.grant_port, bus.grant_onehot, bus.beat_idx,
                     bus.burst_done, bus.burst_abort);
        end
        total++;
        if (bus.beat_fire !== 1'b0) begin
            bad++;
            $display("FAIL reset_beat_fire: got %b want 0", bus.beat_fire);
        end
        bus.rd_req = '0;
        rst_n      = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (bus.grant_valid !== 1'b0 || bus.beat_fire !== 1'b0) begin
            bad++;
            $display("FAIL idle_no_fire: valid=%b fire=%b want 0 0", bus.grant_valid, bus.beat_fire);
        end
    endtask

    task automatic test_single_burst();
        bit ok;
        do_reset();
        bus.sram_ready = 1'b1;
        set_len(0, 6'd3);
        bus.rd_req = 16'h0001;
        @(negedge clk);
        wait_grant(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL single_grant_timeout: got no grant want grant");
        end
        total++;
        if (bus.grant_port !== 4'd0 || bus.grant_onehot !== 16'h0001) begin
            bad++;
            $display("FAIL single_grant_port: got %0d/%h want 0/0001", bus.grant_port, bus.grant_onehot);
        end
        bus.rd_req = '0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (bus.beat_fire !== 1'b1 || bus.beat_idx !== 6'(i) || bus.burst_done !== (i == 2)) begin
                bad++;
                $display("FAIL single_beat%0d: fire=%b idx=%0d done=%b want 1 %0d %0d",
                         i, bus.beat_fire, bus.beat_idx, bus.burst_done, i, (i == 2));
            end
            @(negedge clk);
        end
        total++;
        if (bus.grant_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_end_idle: valid=%b want 0", bus.grant_valid);
        end
    endtask

    task automatic test_round_robin();
        bit          ok;
        logic [15:0] exp_oh;
        do_reset();
        for (int p = 0; p < 16; p++) set_len(p, 6'd1);
        bus.sram_ready = 1'b1;
        bus.rd_req     = 16'hFFFF;
        @(negedge clk);
        wait_grant(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL rr_grant_timeout: got no grant want grant");
        end
        for (int k = 0; k < 17; k++) begin
            exp_oh = 16'h0001 << (k % 16);
            total++;
            if (bus.grant_valid !== 1'b1 || bus.grant_port !== 4'(k % 16) ||
                bus.grant_onehot !== exp_oh || bus.burst_done !== 1'b1) begin
                bad++;
                $display("FAIL rr_grant%0d: valid=%b port=%0d oh=%h done=%b want 1 %0d %h 1",
                         k, bus.grant_valid, bus.grant_port, bus.grant_onehot, bus.burst_done,
                         k % 16, exp_oh);
            end
            @(negedge clk);
            total++;
            if (bus.grant_valid !== 1'b0) begin
                bad++;
                $display("FAIL rr_idle_gap%0d: valid=%b want 0", k, bus.grant_valid);
            end
            @(negedge clk);
        end
        bus.rd_req = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_max_len();
        bit ok;
        int beats;
        int dones;
        int done_at;
        bit idx_ok;
        bus.sram_ready = 1'b1;
        set_len(5, 6'd0);
        bus.rd_req = 16'h0020;
        @(negedge clk);
        wait_grant(ok);
        bus.rd_req = '0;
        beats   = 0;
        dones   = 0;
        done_at = -1;
        idx_ok  = 1'b1;
        for (int c = 0; c < 200; c++) begin
            if (bus.grant_valid !== 1'b1) break;
            if (bus.burst_done === 1'b1) begin
                dones++;
                done_at = beats;
            end
            if (bus.beat_fire === 1'b1) begin
                if (bus.beat_idx !== 6'(beats)) idx_ok = 1'b0;
                beats++;
            end
            @(negedge clk);
        end
        total++;
        if (!ok || beats != 64 || dones != 1 || done_at != 63 || !idx_ok || bus.grant_port !== 4'd5) begin
            bad++;
            $display("FAIL max_len: grant=%b beats=%0d dones=%0d done_at=%0d idx_ok=%b port=%0d want 1 64 1 63 1 5",
                     ok, beats, dones, done_at, idx_ok, bus.grant_port);
        end
    endtask

    task automatic test_stall();
        bit         ok;
        logic [5:0] pat_rdy  = 6'b111001;
        logic [5:0] pat_done = 6'b100000;
        int         exp_idx [6] = '{0, 1, 1, 1, 2, 3};
        bus.sram_ready = 1'b1;
        set_len(3, 6'd4);
        bus.rd_req = 16'h0008;
        @(negedge clk);
        wait_grant(ok);
        bus.rd_req = '0;
        total++;
        if (!ok || bus.grant_port !== 4'd3) begin
            bad++;
            $display("FAIL stall_grant: grant=%b port=%0d want 1 3", ok, bus.grant_port);
        end
        for (int c = 0; c < 6; c++) begin
            bus.sram_ready = pat_rdy[c];
            #1;
            total++;
            if (bus.beat_fire !== pat_rdy[c] || bus.beat_idx !== 6'(exp_idx[c]) ||
                bus.burst_done !== pat_done[c]) begin
                bad++;
                $display("FAIL stall_cycle%0d: fire=%b idx=%0d done=%b want %b %0d %b",
                         c, bus.beat_fire, bus.beat_idx, bus.burst_done,
                         pat_rdy[c], exp_idx[c], pat_done[c]);
            end
            @(negedge clk);
        end
        total++;
        if (bus.grant_valid !== 1'b0) begin
            bad++;
            $display("FAIL stall_end_idle: valid=%b want 0", bus.grant_valid);
        end
    endtask

    task automatic test_req_change();
        bit ok;
        bus.sram_ready = 1'b1;
        set_len(2, 6'd3);
        set_len(7, 6'd2);
        bus.rd_req = 16'h0004;
        @(negedge clk);
        wait_grant(ok);
        bus.rd_req = 16'h0080;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (!ok || bus.grant_port !== 4'd2 || bus.grant_onehot !== 16'h0004 || bus.beat_fire !== 1'b1) begin
                bad++;
                $display("FAIL frozen_beat%0d: port=%0d oh=%h fire=%b want 2 0004 1",
                         i, bus.grant_port, bus.grant_onehot, bus.beat_fire);
            end
            @(negedge clk);
        end
        total++;
        if (bus.grant_valid !== 1'b0) begin
            bad++;
            $display("FAIL frozen_idle: valid=%b want 0", bus.grant_valid);
        end
        @(negedge clk);
        total++;
        if (bus.grant_valid !== 1'b1 || bus.grant_port !== 4'd7) begin
            bad++;
            $display("FAIL next_grant_7: valid=%b port=%0d want 1 7", bus.grant_valid, bus.grant_port);
        end
        bus.rd_req = '0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit ok;
        bus.sram_ready = 1'b1;
        set_len(9, 6'd1);
        bus.rd_req = 16'h0200;
        @(negedge clk);
        wait_grant(ok);
        total++;
        if (!ok || bus.grant_port !== 4'd9) begin
            bad++;
            $display("FAIL regrant_first: grant=%b port=%0d want 1 9", ok, bus.grant_port);
        end
        @(negedge clk);
        @(negedge clk);
        total++;
        if (bus.grant_valid !== 1'b1 || bus.grant_port !== 4'd9) begin
            bad++;
            $display("FAIL regrant_second: valid=%b port=%0d want 1 9", bus.grant_valid, bus.grant_port);
        end
        bus.rd_req = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        bus.sram_ready = 1'b1;
        set_len(4, 6'd10);
        bus.rd_req = 16'h0010;
        @(negedge clk);
        wait_grant(ok);
        bus.rd_req = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (!ok || bus.grant_valid !== 1'b0 || bus.burst_done !== 1'b0 ||
            bus.beat_idx !== 6'd0 || bus.grant_onehot !== 16'h0) begin
            bad++;
            $display("FAIL reset_mid_burst: grant=%b valid=%b done=%b idx=%0d oh=%h want 1 0 0 0 0",
                     ok, bus.grant_valid, bus.burst_done, bus.beat_idx, bus.grant_onehot);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (bus.grant_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_after: valid=%b want 0", bus.grant_valid);
        end
    endtask

    task automatic test_watchdog();
        bit ok;
        int aborts;
        int abort_at;
        do_reset();
        bus.sram_ready = 1'b1;
        set_len(6, 6'd2);
        set_len(11, 6'd1);
`ifdef SRAM_RD_ARB_WDOG_EN
        bus.rd_req = 16'h0840;
`else
        bus.rd_req = 16'h0040;
`endif
        @(negedge clk);
        wait_grant(ok);
        bus.sram_ready = 1'b0;
        total++;
        if (!ok || bus.grant_port !== 4'd6) begin
            bad++;
            $display("FAIL wdog_grant: grant=%b port=%0d want 1 6", ok, bus.grant_port);
        end
        aborts   = 0;
        abort_at = 0;
`ifdef SRAM_RD_ARB_WDOG_EN
        for (int k = 1; k <= 300; k++) begin
            #1;
            if (bus.burst_abort === 1'b1) begin
                abort_at = k;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (abort_at != 255) begin
            bad++;
            $display("FAIL wdog_abort_cycle: got %0d want 255", abort_at);
        end
        @(negedge clk);
        total++;
        if (bus.grant_valid !== 1'b0 || bus.burst_abort !== 1'b0) begin
            bad++;
            $display("FAIL wdog_idle: valid=%b abort=%b want 0 0", bus.grant_valid, bus.burst_abort);
        end
        bus.sram_ready = 1'b1;
        @(negedge clk);
        total++;
        if (bus.grant_valid !== 1'b1 || bus.grant_port !== 4'd11) begin
            bad++;
            $display("FAIL wdog_next_grant: valid=%b port=%0d want 1 11", bus.grant_valid, bus.grant_port);
        end
`else
        for (int k = 1; k <= 300; k++) begin
            #1;
            if (bus.burst_abort === 1'b1) aborts++;
            @(negedge clk);
        end
        total++;
        if (aborts != 0 || bus.grant_valid !== 1'b1 || bus.beat_idx !== 6'd0) begin
            bad++;
            $display("FAIL no_wdog_stall: aborts=%0d valid=%b idx=%0d want 0 1 0",
                     aborts, bus.grant_valid, bus.beat_idx);
        end
        bus.sram_ready = 1'b1;
        #1;
        total++;
        if (bus.beat_fire !== 1'b1 || bus.burst_done !== 1'b0) begin
            bad++;
            $display("FAIL no_wdog_resume0: fire=%b done=%b want 1 0", bus.beat_fire, bus.burst_done);
        end
        @(negedge clk);
        total++;
        if (bus.beat_fire !== 1'b1 || bus.beat_idx !== 6'd1 || bus.burst_done !== 1'b1) begin
            bad++;
            $display("FAIL no_wdog_resume1: fire=%b idx=%0d done=%b want 1 1 1",
                     bus.beat_fire, bus.beat_idx, bus.burst_done);
        end
`endif
        bus.rd_req = '0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        rst_n          = 1'b0;
        bus.rd_req     = '0;
        bus.rd_len     = '0;
        bus.sram_ready = 1'b0;
        test_reset();
        test_single_burst();
        test_round_robin();
        test_max_len();
        test_stall();
        test_req_change();
        test_back_to_back();
        test_reset_mid_burst();
        test_watchdog();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sram_rd_arbiter

`default_nettype wire
